joystick_splitter_scanner: RTL and testbench

Parametrised front end for DB9 joystick hardware that time-multiplexes up to NCHAN joysticks through one physical DB9 port via an external splitter. It drives the splitter select lines, samples each channel after a settle delay, debounces, and applies per-channel autofire. It delivers active-high button vectors to the joystick protocol decoders (Kempston/Sinclair/Cursor/Fuller/OPQA), replacing their fixed two-way 200 Hz multiplexer.

---
 rtl/joystick_splitter_scanner.sv | 122 ++++++++++++
 tb/tb_joystick_splitter_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_splitter_scanner.sv
// DB9 joystick splitter front end: time-multiplexes NCHAN joysticks through one
// port, samples each slot after a settle delay, debounces and applies autofire.
module joystick_splitter_scanner #(
  parameter int unsigned NCHAN    = 2,
  parameter int unsigned W        = 6,
  parameter int unsigned SCAN_DIV = 140000,
  parameter int unsigned SETTLE   = 64,
  parameter int unsigned FIRE_BIT = 4,
  localparam int unsigned SELW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 splitter_en_i,
  input  logic [W-1:0]         joy_i,
  output logic [SELW-1:0]      sel_o,
  output logic [NCHAN*W-1:0]   joy_o,
  input  logic [NCHAN-1:0]     autofire_en_i,
  input  logic [1:0]           af_rate_i,
  input  logic                 vretrace_ni,
  output logic                 frame_done_o
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SELW-1:0]    ch_q, ch_d;
  logic [W-1:0]       prev_q [NCHAN];
  logic [W-1:0]       prev_d [NCHAN];
  logic [W-1:0]       stable_q [NCHAN];
  logic [W-1:0]       stable_d [NCHAN];
  logic [NCHAN*W-1:0] joy_q, joy_d;
  logic               frame_q, frame_d;
  logic               en_q;
  logic               vr_q;
  logic [3:0]         af_q, af_d;
  logic               mode_chg;
  logic               sample;
  logic               gate;

  assign mode_chg = splitter_en_i != en_q;
  assign sample   = cnt_q == CW'(SETTLE);
  assign gate     = af_q[af_rate_i];

  // Slot sequencing, sampling and two-sample debounce (or direct pass-through).
  always_comb begin
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    frame_d  = 1'b0;
    if (!splitter_en_i || mode_chg) begin
      // Direct mode and any mode edge park the scan at channel 0, count 0.
      cnt_d = '0;
      ch_d  = '0;
      for (int unsigned k = 1; k < NCHAN; k++) begin
        stable_d[k] = '0;
        prev_d[k]   = '1;
      end
      if (!splitter_en_i) begin
        stable_d[0] = ~joy_i;
        prev_d[0]   = joy_i;
      end
    end else begin
      if (sample) begin
        for (int unsigned k = 0; k < NCHAN; k++) begin
          if (SELW'(k) == ch_q) begin
            if (joy_i == prev_q[k]) stable_d[k] = ~joy_i;
            prev_d[k] = joy_i;
          end
        end
        frame_d = ch_q == SELW'(NCHAN - 1);
      end
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_d = '0;
        ch_d  = (ch_q == SELW'(NCHAN - 1)) ? '0 : ch_q + SELW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Autofire counter on vretrace rising edges and gated output image.
  always_comb begin
    af_d  = (vretrace_ni && !vr_q) ? af_q + 4'd1 : af_q;
    joy_d = '0;
    for (int unsigned k = 0; k < NCHAN; k++) begin
      joy_d[k*W +: W] = stable_q[k];
      if (autofire_en_i[k]) joy_d[k*W + FIRE_BIT] = stable_q[k][FIRE_BIT] & gate;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    en_q <= splitter_en_i;
    if (!rst_ni) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      joy_q   <= '0;
      frame_q <= 1'b0;
      vr_q    <= 1'b1;
      af_q    <= '0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
        prev_q[k]   <= '1;
        stable_q[k] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      joy_q    <= joy_d;
      frame_q  <= frame_d;
      vr_q     <= vretrace_ni;
      af_q     <= af_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
    end
  end

  assign sel_o        = ch_q;
  assign joy_o        = joy_q;
  assign frame_done_o = frame_q;

endmodule

// File: tb/tb_joystick_splitter_scanner.sv
// Bench for joystick_splitter_scanner: directed scenarios plus a randomized run,
// all checked against a cycle-level reference model kept here.
module tb_joystick_splitter_scanner;

  localparam int NCHAN = 4;
  localparam int W     = 6;
  localparam int SD    = 16;
  localparam int ST    = 4;
  localparam int FB    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  joy;
  logic [3:0]  afen;
  logic [1:0]  rate;
  logic        vr;
  logic [1:0]  sel;
  logic [23:0] joy_out;
  logic        fd;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: t counts cycles since scan start.
  int          t;
  int          af;
  logic [5:0]  m_stable [NCHAN];
  logic [5:0]  m_prev [NCHAN];
  logic        vr_prev;
  logic        en_prev;
  logic [23:0] m_joy;
  logic        m_fd;
  logic [5:0]  tgt [NCHAN];

  always #5 clk = ~clk;

  joystick_splitter_scanner #(
    .NCHAN(NCHAN), .W(W), .SCAN_DIV(SD), .SETTLE(ST), .FIRE_BIT(FB)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .splitter_en_i(en),
    .joy_i(joy),
    .sel_o(sel),
    .joy_o(joy_out),
    .autofire_en_i(afen),
    .af_rate_i(rate),
    .vretrace_ni(vr),
    .frame_done_o(fd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_ch();
    return (t / SD) % NCHAN;
  endfunction

  function automatic int m_cnt();
    return t % SD;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [23:0] nj;
    logic [5:0]  v;
    if (!rst_n) begin
      t = 0;
      af = 0;
      for (int k = 0; k < NCHAN; k++) begin
        m_stable[k] = '0;
        m_prev[k]   = '1;
      end
      vr_prev = 1'b1;
      en_prev = en;
      m_joy   = '0;
      m_fd    = 1'b0;
      return;
    end
    for (int k = 0; k < NCHAN; k++) begin
      v = m_stable[k];
      if (afen[k] && (((af >> rate) & 1) == 0)) v[FB] = 1'b0;
      nj[k*W +: W] = v;
    end
    m_fd = 1'b0;
    if (!en || !en_prev) begin
      t = 0;
      for (int k = 1; k < NCHAN; k++) begin
        m_stable[k] = '0;
        m_prev[k]   = '1;
      end
      if (!en) begin
        m_stable[0] = ~joy;
        m_prev[0]   = joy;
      end
    end else begin
      if (m_cnt() == ST) begin
        if (joy == m_prev[m_ch()]) m_stable[m_ch()] = ~joy;
        m_prev[m_ch()] = joy;
        m_fd = (m_ch() == NCHAN - 1);
      end
      t = (t + 1) % (SD * NCHAN * 1000);
    end
    if (vr && !vr_prev) af = (af + 1) % 16;
    vr_prev = vr;
    en_prev = en;
    m_joy   = nj;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("sel", 32'(sel), 32'(m_ch()));
    check("joy", 32'(joy_out), 32'(m_joy));
    check("frame_done", 32'(fd), 32'(m_fd));
  endtask

  initial begin
    int s;
    int c;
    int ch;
    logic found;
    rst_n = 1'b0;
    en    = 1'b1;
    joy   = 6'h3F;
    afen  = '0;
    rate  = '0;
    vr    = 1'b1;
    for (int k = 0; k < NCHAN; k++) tgt[k] = 6'h3F;
    @(negedge clk);
    step();
    step();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_joy", 32'(joy_out), 32'd0);
    check("rst_fd", 32'(fd), 32'd0);
    rst_n = 1'b1;

    // Scan order, frame pulse timing, debounce and glitch rejection.
    for (int n = 1; n <= 110; n++) begin
      ch = m_ch();
      c  = m_cnt();
      s  = t / (SD * NCHAN);
      joy = 6'h3F;
      if (ch == 2 && s < 2) joy = 6'b111110;
      if (ch == 1 && s == 0) joy = 6'b111101;
      if (ch == 3 && c < ST) joy = 6'b011111;
      step();
      if (n == 15) check("scan_sel0", 32'(sel), 32'd0);
      if (n == 16) check("scan_sel1", 32'(sel), 32'd1);
      if (n == 48) check("scan_sel3", 32'(sel), 32'd3);
      if (n == 52) check("fd_early", 32'(fd), 32'd0);
      if (n == 53) check("fd_pulse", 32'(fd), 32'd1);
      if (n == 101) check("deb_wait", 32'(joy_out[17:12]), 32'd0);
      if (n == 102) check("deb_take", 32'(joy_out[17:12]), 32'b000001);
      if (n == 110) begin
        check("deb_single", 32'(joy_out[11:6]), 32'd0);
        check("glitch", 32'(joy_out[23:18]), 32'd0);
      end
    end

    // Autofire on channel 1, rate 2; channel 0 not gated.
    joy  = 6'b101111;
    afen = 4'b0010;
    rate = 2'd2;
    for (int i = 0; i < 140; i++) step();
    check("af_start", 32'(joy_out[10]), 32'd0);
    for (int j = 1; j <= 8; j++) begin
      vr = 1'b0;
      step();
      step();
      vr = 1'b1;
      step();
      step();
      step();
      check("af_ch1", 32'(joy_out[10]), 32'(j >= 4 && j <= 7));
      check("af_ch0", 32'(joy_out[4]), 32'd1);
    end

    // Direct mode.
    en  = 1'b0;
    joy = 6'b011111;
    step();
    step();
    check("direct_lo", 32'(joy_out[5:0]), 32'b100000);
    check("direct_hi", 32'(joy_out[23:6]), 32'd0);
    check("direct_sel", 32'(sel), 32'd0);

    // Reset mid-slot at channel 2, count 9.
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = (m_ch() == 2 && m_cnt() == 9);
    end
    check("reach_mid", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_sel", 32'(sel), 32'd0);
    check("mid_joy", 32'(joy_out), 32'd0);
    check("mid_fd", 32'(fd), 32'd0);
    rst_n = 1'b1;

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NCHAN; k++)
        if ($urandom_range(99) == 0) tgt[k] = 6'($urandom);
      if ($urandom_range(5) == 0) vr = ~vr;
      if ($urandom_range(199) == 0) afen = 4'($urandom);
      if ($urandom_range(299) == 0) rate = 2'($urandom);
      if ($urandom_range(699) == 0) en = ~en;
      rst_n = ($urandom_range(899) != 0);
      joy = en ? tgt[m_ch()] : tgt[0];
      if ($urandom_range(7) == 0) joy = 6'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
